xswitch_conn_ctrl: RTL and testbench
====================================

Name: xswitch_conn_ctrl

Overview:
- Per-target connection scheduler for the crossbar request path.
- Each target gets its own round-robin arbiter. The winning initiator keeps the target until a beat with `last` is accepted. Turns single-cycle arbitration into packet-level locking.
- Release also happens on request withdrawal or on a stall timeout.
- Sits between initiator request ports and the crossbar mux select; drives the mux select and per-initiator grants.

Parameters:
- NUM_I, 3, number of initiators (≥2)
- NUM_T, 5, number of targets (≥1)
- MAX_HOLD, 16, stall-timeout threshold: consecutive BUSY cycles with no accepted beat before a forced release (≥2)
- IW, $clog2(NUM_I), owner index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  [NUM_I][NUM_T]  per-initiator target request; each row onehot0
- i_valid  in  NUM_I  initiator beat valid
- i_last  in  NUM_I  final beat of packet, qualified by i_valid
- t_rdy  in  NUM_T  target accepts beat
- i_gnt  out  [NUM_I][NUM_T]  registered grant: initiator i owns target t
- t_sel  out  [NUM_T][IW]  owner index per target for the mux; 0 when idle
- t_busy  out  NUM_T  target locked
- t_timeout  out  NUM_T  one-cycle pulse on forced release

Behaviour:
- Reset:
  - Synchronous, active-high, overrides everything.
  - All targets go IDLE; i_gnt, t_sel, t_busy and t_timeout go to 0.
  - RR pointers go to 0; hold counters go to 0.
  - Reset mid-packet drops the lock with no timeout pulse.
- Per-target FSM has two states, IDLE and BUSY.
- IDLE:
  - Candidates are all i with i_req[i][t]=1.
  - Pick the first candidate at or after ptr[t], modulo NUM_I.
  - With no candidate, stay IDLE.
  - With a winner k, go BUSY next cycle: owner=k, i_gnt[k][t]=1, t_sel[t]=k, t_busy[t]=1.
  - Grant latency is 1 cycle from the request being sampled in IDLE.
  - Arbitration ignores t_rdy.
- BUSY with owner k:
  - Beat accepted = i_valid[k] & t_rdy[t].
  - Accepted beat with i_last[k]=1: go IDLE next cycle and set ptr[t]=(k+1) mod NUM_I.
  - i_req[k][t]=0 with no accepted last: withdrawal, same release and pointer update.
  - Hold counter clears on every accepted beat, otherwise increments, saturating at MAX_HOLD.
  - Counter reaching MAX_HOLD-1 with no accept this cycle: forced release, same pointer update, t_timeout[t]=1 for exactly one cycle (the cycle after release).
  - An accepted last beat in the timeout cycle wins: normal release, no pulse.
- Turnaround:
  - Release cycle N gives IDLE at N+1, arbitration at N+1, new grant visible at N+2.
  - Minimum one idle cycle between owners; the same initiator re-requesting also sees the gap.
- Simultaneous requests: all targets arbitrate independently in the same cycle.
- Invariants (sim-only checks, excluded under SYNTHESIS):
  - Each column of i_gnt is onehot0.
  - Each row of i_gnt is onehot0, which follows from the onehot0 i_req rows.
  - Rows of i_req must be onehot0; this is an input requirement with a sim check.
- The counter needs $clog2(MAX_HOLD+1) bits.

Decomposition:
- Shared package xswitch_pkg holds:
  - enum `conn_state_e` {IDLE, BUSY}
  - default NUM_I / NUM_T constants
  - a function for the rotate-priority onehot pick
- Natural sub-module: xswitch_conn_slot, one instance per target. It contains the FSM, owner register, RR pointer and hold counter, and is generated NUM_T times.
- The top level only transposes i_req columns into slots and gathers grants back into rows.

Test Plan:
- Single packet, NUM_I=3, NUM_T=5, MAX_HOLD=16:
  - Stimulus: I1 requests T2 at cycle 0; valid with t_rdy=1 for 3 beats, last on beat 3.
  - Response: i_gnt[1][2]=1 from cycle 1; released after the last beat; t_sel[2]=1 while busy.
- Round-robin fairness:
  - Stimulus: I0, I1, I2 all request T0 continuously; each sends a 1-beat last packet.
  - Response: owners in order 0,1,2,0; each grant 2 cycles after the previous release; never two grants in column 0.
- Lock across contention:
  - Stimulus: I0 holds T3 mid-packet when I2 starts requesting T3.
  - Response: I2 is not granted until the cycle after I0's last beat plus one; t_busy[3] stays 1 throughout.
- Stall timeout:
  - Stimulus: I1 owns T4, t_rdy[4]=0 for 20 cycles.
  - Response: forced release after 16 BUSY cycles, t_timeout[4] pulses once, ptr[4]=2.
- Withdrawal and reset:
  - Stimulus: I2 drops i_req mid-packet; later rst=1 is asserted while T0 and T1 are busy.
  - Response: release the next cycle after the drop; after reset all outputs are 0 and the next grant starts from I0.

Source files
------------

// File: rtl/xswitch_pkg.sv
// Shared types and helpers for the crossbar connection scheduler.
// Holds the per-target FSM encoding, default sizes and the rotate-priority pick.
package xswitch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } conn_state_e;

  localparam int DEF_NUM_I = 3;
  localparam int DEF_NUM_T = 5;

  // Onehot of the first set bit of req at or after ptr, wrapping modulo n (n <= 32).
  function automatic logic [31:0] rr_pick(input logic [31:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    logic [31:0] pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (pick == '0 && req[idx[4:0]]) pick[idx[4:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/xswitch_conn_slot.sv
// One target's connection lock: round-robin arbitration in IDLE, packet-level
// ownership in BUSY, released on last beat, request withdrawal or stall timeout.
module xswitch_conn_slot
  import xswitch_pkg::*;
#(
  parameter int NUM_I    = DEF_NUM_I,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(NUM_I)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_I-1:0] req,
  input  logic [NUM_I-1:0] valid,
  input  logic [NUM_I-1:0] last,
  input  logic             rdy,
  output logic [NUM_I-1:0] gnt,
  output logic [IW-1:0]    sel,
  output logic             busy,
  output logic             timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  conn_state_e     state_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   ptr_reg;
  logic [CW-1:0]   hold_reg;
  logic            timeout_reg;

  logic [NUM_I-1:0] pick;
  logic [IW-1:0]    win_idx;
  logic             any_req;
  logic             accept;
  logic             last_acc;
  logic             withdraw;
  logic             stall_out;
  logic [IW-1:0]    ptr_next;

  always_comb begin
    pick    = NUM_I'(rr_pick(32'(req), 32'(ptr_reg), 32'(NUM_I)));
    any_req = |req;
    win_idx = '0;
    for (int i = 0; i < NUM_I; i++) begin
      if (pick[i]) win_idx = IW'(i);
    end
  end

  assign accept    = valid[owner_reg] & rdy;
  assign last_acc  = accept & last[owner_reg];
  assign withdraw  = ~req[owner_reg];
  assign stall_out = ~accept && (hold_reg == CW'(MAX_HOLD - 1));
  assign ptr_next  = (owner_reg == IW'(NUM_I - 1)) ? '0 : owner_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      ptr_reg     <= '0;
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg <= BUSY;
            owner_reg <= win_idx;
            hold_reg  <= '0;
          end
        end
        BUSY: begin
          // Release priority: accepted last, then withdrawal, then stall timeout.
          if (last_acc || withdraw) begin
            state_reg <= IDLE;
            ptr_reg   <= ptr_next;
            hold_reg  <= '0;
          end else if (stall_out) begin
            state_reg   <= IDLE;
            ptr_reg     <= ptr_next;
            hold_reg    <= '0;
            timeout_reg <= 1'b1;
          end else if (accept) begin
            hold_reg <= '0;
          end else if (hold_reg != CW'(MAX_HOLD)) begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = (state_reg == BUSY);
  assign sel     = busy ? owner_reg : '0;
  assign timeout = timeout_reg;

  for (genvar gi = 0; gi < NUM_I; gi++) begin : g_gnt
    assign gnt[gi] = busy && (owner_reg == IW'(gi));
  end

endmodule

// File: rtl/xswitch_conn_ctrl.sv
// Per-target connection scheduler: one lock slot per target column of i_req,
// grants gathered back into per-initiator rows for the crossbar.
module xswitch_conn_ctrl
  import xswitch_pkg::*;
#(
  parameter int NUM_I    = DEF_NUM_I,
  parameter int NUM_T    = DEF_NUM_T,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(NUM_I)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_I-1:0][NUM_T-1:0] i_req,
  input  logic [NUM_I-1:0]            i_valid,
  input  logic [NUM_I-1:0]            i_last,
  input  logic [NUM_T-1:0]            t_rdy,
  output logic [NUM_I-1:0][NUM_T-1:0] i_gnt,
  output logic [NUM_T-1:0][IW-1:0]    t_sel,
  output logic [NUM_T-1:0]            t_busy,
  output logic [NUM_T-1:0]            t_timeout
);

  logic [NUM_T-1:0][NUM_I-1:0] req_cols;
  logic [NUM_T-1:0][NUM_I-1:0] gnt_cols;

  for (genvar gi = 0; gi < NUM_T; gi++) begin : g_tgt
    for (genvar gj = 0; gj < NUM_I; gj++) begin : g_xpose
      assign req_cols[gi][gj] = i_req[gj][gi];
      assign i_gnt[gj][gi]    = gnt_cols[gi][gj];
    end

    xswitch_conn_slot #(
      .NUM_I    (NUM_I),
      .MAX_HOLD (MAX_HOLD)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .req     (req_cols[gi]),
      .valid   (i_valid),
      .last    (i_last),
      .rdy     (t_rdy[gi]),
      .gnt     (gnt_cols[gi]),
      .sel     (t_sel[gi]),
      .busy    (t_busy[gi]),
      .timeout (t_timeout[gi])
    );
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int t = 0; t < NUM_T; t++) begin
        assert ($onehot0(gnt_cols[t])) else $error("grant column %0d not onehot0", t);
      end
      for (int i = 0; i < NUM_I; i++) begin
        assert ($onehot0(i_gnt[i])) else $error("grant row %0d not onehot0", i);
        assert ($onehot0(i_req[i])) else $error("request row %0d not onehot0", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_xswitch_conn_ctrl.sv
// Randomized and directed bench for xswitch_conn_ctrl against a per-target
// ownership model (owner or none, rotation pointer, stall count).
module tb_xswitch_conn_ctrl;

  localparam int NUM_I    = 3;
  localparam int NUM_T    = 5;
  localparam int MAX_HOLD = 16;
  localparam int IW       = $clog2(NUM_I);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [NUM_I-1:0][NUM_T-1:0] i_req;
  logic [NUM_I-1:0]            i_valid;
  logic [NUM_I-1:0]            i_last;
  logic [NUM_T-1:0]            t_rdy;
  logic [NUM_I-1:0][NUM_T-1:0] i_gnt;
  logic [NUM_T-1:0][IW-1:0]    t_sel;
  logic [NUM_T-1:0]            t_busy;
  logic [NUM_T-1:0]            t_timeout;

  xswitch_conn_ctrl #(
    .NUM_I    (NUM_I),
    .NUM_T    (NUM_T),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .t_rdy     (t_rdy),
    .i_gnt     (i_gnt),
    .t_sel     (t_sel),
    .t_busy    (t_busy),
    .t_timeout (t_timeout)
  );

  // Model: owner per target (-1 = free), next-priority initiator, cycles owned without progress.
  int m_own   [NUM_T];
  int m_ptr   [NUM_T];
  int m_stall [NUM_T];
  bit m_tout  [NUM_T];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int tgt     [NUM_I];

  function automatic void model_reset();
    for (int t = 0; t < NUM_T; t++) begin
      m_own[t] = -1; m_ptr[t] = 0; m_stall[t] = 0; m_tout[t] = 0;
    end
  endfunction

  function automatic void model_release(int t, bit forced);
    m_ptr[t]   = (m_own[t] + 1) % NUM_I;
    m_own[t]   = -1;
    m_stall[t] = 0;
    m_tout[t]  = forced;
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int t = 0; t < NUM_T; t++) begin
      m_tout[t] = 0;
      if (m_own[t] < 0) begin
        for (int n = 0; n < NUM_I; n++) begin
          int c;
          c = (m_ptr[t] + n) % NUM_I;
          if (m_own[t] < 0 && i_req[c][t]) begin
            m_own[t] = c; m_stall[t] = 0;
          end
        end
      end else begin
        int k;
        bit acc;
        k = m_own[t];
        acc = i_valid[k] && t_rdy[t];
        if (acc && i_last[k])            model_release(t, 0);
        else if (!i_req[k][t])           model_release(t, 0);
        else if (!acc && m_stall[t] + 1 >= MAX_HOLD) model_release(t, 1);
        else if (acc)                    m_stall[t] = 0;
        else                             m_stall[t] = m_stall[t] + 1;
      end
    end
  endfunction

  task automatic compare();
    logic [NUM_I-1:0][NUM_T-1:0] e_gnt;
    logic [NUM_T-1:0][IW-1:0]    e_sel;
    logic [NUM_T-1:0]            e_busy, e_tout;
    e_gnt = '0; e_sel = '0; e_busy = '0; e_tout = '0;
    for (int t = 0; t < NUM_T; t++) begin
      if (m_own[t] >= 0) begin
        e_gnt[m_own[t]][t] = 1'b1;
        e_sel[t]  = IW'(m_own[t]);
        e_busy[t] = 1'b1;
      end
      e_tout[t] = m_tout[t];
    end
    vectors++;
    if (i_gnt !== e_gnt) begin
      errors++; $display("FAIL i_gnt cyc=%0d got %h exp %h", cyc, i_gnt, e_gnt);
    end
    if (t_sel !== e_sel) begin
      errors++; $display("FAIL t_sel cyc=%0d got %h exp %h", cyc, t_sel, e_sel);
    end
    if (t_busy !== e_busy) begin
      errors++; $display("FAIL t_busy cyc=%0d got %h exp %h", cyc, t_busy, e_busy);
    end
    if (t_timeout !== e_tout) begin
      errors++; $display("FAIL t_timeout cyc=%0d got %h exp %h", cyc, t_timeout, e_tout);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++; $display("FAIL %s cyc=%0d got %0d exp %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic quiet();
    i_req = '0; i_valid = '0; i_last = '0; t_rdy = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; quiet(); tick(); rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; quiet();
    tick(); tick();
    check_lit("reset_busy", int'(t_busy), 0);
    check_lit("reset_gnt", int'(i_gnt), 0);
    rst = 1'b0;

    // Single packet: I1 -> T2, three beats, last on the third.
    i_req[1][2] = 1'b1; i_valid[1] = 1'b1; t_rdy = '1;
    tick();
    check_lit("pkt_gnt", int'(i_gnt[1][2]), 1);
    check_lit("pkt_sel", int'(t_sel[2]), 1);
    tick(); tick();
    check_lit("pkt_busy_mid", int'(t_busy[2]), 1);
    i_last[1] = 1'b1;
    tick();
    check_lit("pkt_released", int'(t_busy[2]), 0);
    quiet(); tick();

    // Round robin on T0 with one-beat packets.
    do_reset();
    i_req[0][0] = 1; i_req[1][0] = 1; i_req[2][0] = 1;
    i_valid = '1; i_last = '1; t_rdy = '1;
    tick(); check_lit("rr_own0", int'(i_gnt[0][0]), 1);
    tick(); check_lit("rr_gap", int'(t_busy[0]), 0);
    tick(); check_lit("rr_own1", int'(t_sel[0]), 1);
    tick(); tick(); check_lit("rr_own2", int'(t_sel[0]), 2);
    tick(); tick(); check_lit("rr_own0b", int'(i_gnt[0][0]), 1);
    quiet(); tick(); tick();

    // Lock held by I0 on T3 while I2 contends.
    do_reset();
    i_req[0][3] = 1; i_valid[0] = 1; t_rdy = '1;
    tick();
    i_req[2][3] = 1;
    tick(); tick();
    check_lit("lock_owner", int'(t_sel[3]), 0);
    check_lit("lock_busy", int'(t_busy[3]), 1);
    i_last[0] = 1;
    tick();
    check_lit("lock_gap", int'(t_busy[3]), 0);
    i_last[0] = 0; i_req[0][3] = 0;
    tick();
    check_lit("lock_next", int'(i_gnt[2][3]), 1);
    quiet(); tick(); tick();

    // Stall timeout on T4 owned by I1.
    do_reset();
    i_req[1][4] = 1; i_valid[1] = 1; t_rdy = '0;
    for (int n = 0; n < 16; n++) tick();
    check_lit("to_still_busy", int'(t_busy[4]), 1);
    check_lit("to_no_pulse", int'(t_timeout[4]), 0);
    i_req[2][4] = 1;
    tick();
    check_lit("to_released", int'(t_busy[4]), 0);
    check_lit("to_pulse", int'(t_timeout[4]), 1);
    tick();
    check_lit("to_pulse_end", int'(t_timeout[4]), 0);
    check_lit("to_ptr2", int'(i_gnt[2][4]), 1);
    quiet(); tick(); tick();

    // Withdrawal by I2 on T1.
    do_reset();
    i_req[2][1] = 1;
    tick(); tick();
    check_lit("wd_busy", int'(t_busy[1]), 1);
    i_req[2][1] = 0;
    tick();
    check_lit("wd_released", int'(t_busy[1]), 0);

    // Reset while T0 and T1 are busy, then grant restarts from I0.
    i_req[1][0] = 1; i_req[0][1] = 1;
    tick();
    check_lit("rst_pre_busy", int'(t_busy[1:0]), 3);
    rst = 1'b1;
    tick();
    check_lit("rst_gnt", int'(i_gnt), 0);
    check_lit("rst_tout", int'(t_timeout), 0);
    rst = 1'b0; quiet();
    i_req[0][0] = 1; i_req[1][0] = 1;
    tick();
    check_lit("rst_ptr0", int'(i_gnt[0][0]), 1);
    quiet(); tick(); tick();

    // Randomized traffic with varying target readiness.
    for (int i = 0; i < NUM_I; i++) tgt[i] = -1;
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      case (seg)
        0: rdy_pct = 90;
        1: rdy_pct = 60;
        2: rdy_pct = 20;
        3: rdy_pct = 3;
        4: rdy_pct = 70;
        default: rdy_pct = 40;
      endcase
      for (int n = 0; n < 500; n++) begin
        i_req = '0;
        for (int i = 0; i < NUM_I; i++) begin
          if ($urandom_range(99) < 8) begin
            int r;
            r = int'($urandom_range(NUM_T));
            tgt[i] = (r == NUM_T) ? -1 : r;
          end
          if (tgt[i] >= 0) i_req[i][tgt[i]] = 1'b1;
          i_valid[i] = ($urandom_range(99) < 60);
          i_last[i]  = ($urandom_range(99) < 30);
        end
        for (int t = 0; t < NUM_T; t++) t_rdy[t] = ($urandom_range(99) < rdy_pct);
        rst = ($urandom_range(999) < 4);
        tick();
      end
    end
    rst = 1'b0; quiet();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
